quad_position_decoder: RTL and testbench

QUAD_POSITION_DECODER -- requirements
Module: quad_position_decoder

---
 rtl/quad_pkg.sv | 28 ++
 rtl/sig_filter.sv | 40 ++++
 rtl/quad_position_decoder.sv | 127 ++++++++++++
 tb/tb_quad_position_decoder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared widths, limits and decoder state encoding for the quadrature position decoder.
package quad_pkg;

  localparam int POS_W = 10;
  localparam int ERR_W = 8;
  localparam logic [POS_W-1:0] CENTER_DEFAULT = 10'd512;
  localparam logic [POS_W-1:0] POS_MAX = 10'd1023;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

  typedef enum logic {
    PRIME = 1'b0,
    TRACK = 1'b1
  } dec_state_t;

  // Position of an AB pair around the x4 cycle 00->01->11->10, so that a
  // forward step is +1 and a reverse step is -1 modulo 4.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sig_filter.sv
// Two-flop synchronizer plus glitch filter; dout follows din after 2 + FILTER_LEN cycles.
// No backpressure: free-running, pulses shorter than FILTER_LEN cycles are dropped.
module sig_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= 4'd0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // cnt holds how many consecutive cycles sync2 has disagreed with dout;
      // the FILTER_LEN-th disagreeing cycle commits the new value.
      if (sync2 != dout) begin
        if (cnt == 4'(FILTER_LEN - 1)) begin
          dout <= sync2;
          cnt  <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/quad_position_decoder.sv
// x4 quadrature decoder with saturating position, error counting and index homing.
// Latency FILTER_LEN+3 clk edges from first synchronizer flop to outputs; no backpressure.
module quad_position_decoder
  import quad_pkg::*;
#(
  parameter int               FILTER_LEN = 3,
  parameter logic [POS_W-1:0] CENTER     = CENTER_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_z,
  input  logic             home_en,
  output logic [POS_W-1:0] position,
  output logic             direction,
  output logic             step,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             homed
);

  logic a_f;
  logic b_f;
  logic z_f;

  sig_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .reset(reset), .din(enc_a), .dout(a_f));
  sig_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .reset(reset), .din(enc_b), .dout(b_f));
  sig_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (.clk(clk), .reset(reset), .din(enc_z), .dout(z_f));

  dec_state_t       state;
  dec_state_t       state_n;
  logic [3:0]       prime_cnt;
  logic [3:0]       prime_cnt_n;
  logic [1:0]       ab_q;
  logic [1:0]       ref_ab;
  logic [1:0]       ref_n;
  logic             z_q;
  logic             z_prev;
  logic [POS_W-1:0] pos_n;
  logic             dir_n;
  logic             step_n;
  logic             err_n;
  logic [ERR_W-1:0] errc_n;
  logic             homed_n;
  logic [1:0]       delta;

  // ab_q/z_q register the filter outputs so decode logic sees clean flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PRIME;
      prime_cnt <= 4'd0;
      ab_q      <= 2'b00;
      ref_ab    <= 2'b00;
      z_q       <= 1'b0;
      z_prev    <= 1'b0;
      position  <= CENTER;
      direction <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      homed     <= 1'b0;
    end else begin
      state     <= state_n;
      prime_cnt <= prime_cnt_n;
      ab_q      <= {a_f, b_f};
      ref_ab    <= ref_n;
      z_q       <= z_f;
      z_prev    <= z_q;
      position  <= pos_n;
      direction <= dir_n;
      step      <= step_n;
      err       <= err_n;
      err_count <= errc_n;
      homed     <= homed_n;
    end
  end

  always_comb begin
    state_n     = state;
    prime_cnt_n = prime_cnt;
    ref_n       = ref_ab;
    pos_n       = position;
    dir_n       = direction;
    step_n      = 1'b0;
    err_n       = 1'b0;
    errc_n      = err_count;
    homed_n     = homed;
    delta       = gray_idx(ab_q) - gray_idx(ref_ab);

    case (state)
      PRIME: begin
        if (prime_cnt == 4'(FILTER_LEN - 1)) begin
          ref_n   = ab_q;
          state_n = TRACK;
        end else begin
          prime_cnt_n = prime_cnt + 4'd1;
        end
      end
      TRACK: begin
        if (ab_q != ref_ab) begin
          ref_n = ab_q;
          if (&(ab_q ^ ref_ab)) begin
            err_n = 1'b1;
            if (err_count != ERR_MAX) errc_n = err_count + 1'b1;
          end else begin
            step_n = 1'b1;
            dir_n  = (delta == 2'd1);
            if (delta == 2'd1) begin
              if (position != POS_MAX) pos_n = position + 1'b1;
            end else if (position != '0) begin
              pos_n = position - 1'b1;
            end
          end
        end
      end
      default: state_n = PRIME;
    endcase

    // Index load overrides any step decoded in the same cycle.
    if (home_en && z_q && !z_prev) begin
      pos_n   = CENTER;
      homed_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_quad_position_decoder.sv
// Randomized and directed bench for quad_position_decoder against a cycle-level reference model.
module tb_quad_position_decoder;

  localparam int N   = 3;
  localparam int CTR = 512;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       enc_z = 1'b0;
  logic       home_en = 1'b0;
  logic [9:0] position;
  logic       direction;
  logic       step;
  logic       err;
  logic [7:0] err_count;
  logic       homed;

  quad_position_decoder #(.FILTER_LEN(N), .CENTER(10'd512)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .home_en(home_en), .position(position), .direction(direction), .step(step),
    .err(err), .err_count(err_count), .homed(homed)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int step_seen = 0;
  int err_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-channel run-length filter on raw samples, a four
  // sample delay for synchronizer and pipeline, then x4 decode by cycle index.
  int       m_pos;
  bit       m_dir, m_step, m_err, m_homed, m_zprev;
  int       m_errc;
  bit       f_a, f_b, f_z;
  int       r_a, r_b, r_z;
  bit [1:0] m_ref;
  bit [2:0] dq [4];
  int       ord [4] = '{0, 1, 3, 2};

  task automatic model_reset();
    m_pos = CTR; m_dir = 0; m_step = 0; m_err = 0; m_errc = 0; m_homed = 0;
    f_a = 0; f_b = 0; f_z = 0; r_a = 0; r_b = 0; r_z = 0; m_ref = 0; m_zprev = 0;
    for (int i = 0; i < 4; i++) dq[i] = 3'b000;
  endtask

  task automatic filt(inout bit f, inout int r, input bit x);
    if (x != f) begin
      r++;
      if (r == N) begin
        f = x;
        r = 0;
      end
    end else begin
      r = 0;
    end
  endtask

  task automatic model_decode(input bit [2:0] t);
    bit [1:0] ab;
    int d;
    ab = t[2:1];
    m_step = 0;
    m_err = 0;
    if (ab != m_ref) begin
      if ((ab ^ m_ref) == 2'b11) begin
        m_err = 1;
        m_errc = (m_errc < 255) ? m_errc + 1 : 255;
      end else begin
        d = (ord[ab] - ord[m_ref] + 4) % 4;
        m_step = 1;
        m_dir = (d == 1);
        m_pos = (d == 1) ? ((m_pos < 1023) ? m_pos + 1 : 1023) : ((m_pos > 0) ? m_pos - 1 : 0);
      end
      m_ref = ab;
    end
    if (t[0] && !m_zprev && home_en) begin
      m_pos = CTR;
      m_homed = 1;
    end
    m_zprev = t[0];
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      model_decode(dq[3]);
      for (int i = 3; i > 0; i--) dq[i] = dq[i-1];
      filt(f_a, r_a, enc_a);
      filt(f_b, r_b, enc_b);
      filt(f_z, r_z, enc_z);
      dq[0] = {f_a, f_b, f_z};
    end
  end

  always @(negedge clk) begin
    check("position", position, m_pos);
    check("direction", direction, m_dir);
    check("step", step, m_step);
    check("err", err, m_err);
    check("err_count", err_count, m_errc);
    check("homed", homed, m_homed);
    if (step === 1'b1) step_seen++;
    if (err === 1'b1) err_seen++;
  end

  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int ph = 0;

  task automatic hold(input logic [1:0] ab, input logic z, input int n);
    enc_a = ab[1];
    enc_b = ab[0];
    enc_z = z;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic fwd(input int n, input int h);
    repeat (n) begin
      ph = (ph + 1) % 4;
      hold(gray[ph], 1'b0, h);
    end
  endtask

  task automatic rev(input int n, input int h);
    repeat (n) begin
      ph = (ph + 3) % 4;
      hold(gray[ph], 1'b0, h);
    end
  endtask

  // Called at posedge+2; asserts reset, checks outputs asynchronously, releases.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_position", position, CTR);
    check("rst_direction", direction, 0);
    check("rst_step", step, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_homed", homed, 0);
    enc_a = 0; enc_b = 0; enc_z = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    ph = 0;
    hold(2'b00, 1'b0, 10);
  endtask

  // Inputs were just driven at posedge+2; the next edge samples them.
  task automatic lat_check(input string tag, input bit use_homed, input int zoff);
    logic v;
    for (int k = 1; k <= N + 4; k++) begin
      @(posedge clk);
      #1;
      if (k == zoff) enc_z = 1'b0;
      v = use_homed ? homed : step;
      check(tag, v, (k == N + 4));
    end
    #1;
  endtask

  initial begin
    int r;
    @(posedge clk);
    #2;
    do_reset();

    // Forward cycle with latency probe on the first edge.
    step_seen = 0; err_seen = 0;
    ph = 1; enc_b = 1'b1;
    lat_check("lat_step", 1'b0, 0);
    hold(gray[ph], 1'b0, 2);
    fwd(3, 8);
    hold(2'b00, 1'b0, 8);
    check("fwd_position", position, 516);
    check("fwd_direction", direction, 1);
    check("fwd_steps", step_seen, 4);
    check("fwd_errs", err_seen, 0);

    // Reverse two full cycles from center.
    do_reset();
    step_seen = 0;
    rev(8, 8);
    hold(2'b00, 1'b0, 8);
    check("rev_position", position, 504);
    check("rev_direction", direction, 0);
    check("rev_steps", step_seen, 8);

    // Glitch rejection: 2-cycle pulse dropped, 3-cycle pulse accepted.
    step_seen = 0; err_seen = 0;
    hold(2'b10, 1'b0, 2);
    hold(2'b00, 1'b0, 10);
    check("glitch_steps", step_seen, 0);
    check("glitch_errs", err_seen, 0);
    check("glitch_position", position, 504);
    hold(2'b10, 1'b0, 3);
    hold(2'b00, 1'b0, 10);
    check("pulse3_steps", step_seen, 2);
    check("pulse3_position", position, 504);
    check("pulse3_direction", direction, 1);

    // Illegal double transitions and err_count saturation.
    step_seen = 0; err_seen = 0;
    hold(2'b11, 1'b0, 8);
    check("err1_seen", err_seen, 1);
    check("err1_count", err_count, 1);
    check("err1_position", position, 504);
    check("err1_direction", direction, 1);
    for (int i = 1; i < 300; i++) hold((i % 2) ? 2'b00 : 2'b11, 1'b0, 4);
    hold(2'b00, 1'b0, 8);
    check("err_sat_count", err_count, 255);
    check("err_sat_seen", err_seen, 300);
    check("err_steps", step_seen, 0);

    // Position saturation at both limits.
    do_reset();
    step_seen = 0;
    fwd(600, 4);
    hold(gray[ph], 1'b0, 8);
    check("sat_hi_position", position, 1023);
    check("sat_hi_steps", step_seen, 600);
    step_seen = 0;
    rev(1100, 4);
    hold(gray[ph], 1'b0, 8);
    check("sat_lo_position", position, 0);
    check("sat_lo_steps", step_seen, 1100);
    check("sat_lo_direction", direction, 0);

    // Index homing, ignored index, reset mid-pulse.
    do_reset();
    fwd(18, 4);
    hold(gray[ph], 1'b0, 8);
    check("pre_home_position", position, 530);
    home_en = 1'b1;
    enc_z = 1'b1;
    lat_check("lat_homed", 1'b1, 5);
    hold(gray[ph], 1'b0, 6);
    check("home_position", position, CTR);
    check("home_homed", homed, 1);
    home_en = 1'b0;
    fwd(3, 4);
    hold(gray[ph], 1'b1, 5);
    hold(gray[ph], 1'b0, 8);
    check("noarm_position", position, 515);
    home_en = 1'b1;
    hold(gray[ph], 1'b1, 2);
    do_reset();
    home_en = 1'b0;
    step_seen = 0;
    fwd(1, 8);
    check("restart_position", position, 513);
    check("restart_steps", step_seen, 1);
    check("restart_homed", homed, 0);

    // Random segments: steps, double changes, short glitches, index pulses.
    do_reset();
    for (int s = 0; s < 700; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) ph = (ph + 1) % 4;
      else if (r < 7) ph = (ph + 3) % 4;
      else ph = int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) home_en = ~home_en;
      hold(gray[ph], ($urandom_range(0, 11) == 0), int'($urandom_range(1, 6)));
    end
    hold(gray[ph], 1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "time limit");
  end

endmodule
